// File: rtl/minimig_mem_pkg.sv
// Shared definitions for the Amiga bank mapping / memory responder slice.
// Holds the responder state encoding, bank-select widths, the bit position
// of each bank in the one-hot select, and the value returned by reads of
// unmapped space.
package minimig_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        RELEASE
    } state_t;

    localparam int unsigned BANK_W     = 8;
    localparam int unsigned BANK_IDX_W = 3;

    // Bit positions in the one-hot bank select
    localparam int unsigned BANK_KICK    = 7;
    localparam int unsigned BANK_KICK1MB = 6;
    localparam int unsigned BANK_SLOW1   = 5;
    localparam int unsigned BANK_SLOW0   = 4;
    localparam int unsigned BANK_CHIP3   = 3;
    localparam int unsigned BANK_CHIP2   = 2;
    localparam int unsigned BANK_CHIP1   = 1;
    localparam int unsigned BANK_CHIP0   = 0;

    localparam logic [15:0] UNMAPPED_READ = 16'hFFFF;

endpackage

// File: rtl/minimig_bank_responder_if.sv
// Bus-side connection between a requesting master and the bank responder.
// master: drives req/we/bank/ofs/wdata/be, receives ack/berr/rdata/unmapped.
// slave : the responder side of the same signals.
interface minimig_bank_responder_if
    import minimig_mem_pkg::*;
#(
    parameter int unsigned OFS_W = 18
);
    logic              req;
    logic              we;
    logic [BANK_W-1:0] bank;
    logic [OFS_W-1:0]  ofs;
    logic [15:0]       wdata;
    logic [1:0]        be;
    logic              ack;
    logic              berr;
    logic [15:0]       rdata;
    logic              unmapped;

    modport master (
        output req, we, bank, ofs, wdata, be,
        input  ack, berr, rdata, unmapped
    );

    modport slave (
        input  req, we, bank, ofs, wdata, be,
        output ack, berr, rdata, unmapped
    );
endinterface

// File: rtl/minimig_onehot_enc.sv
// One-hot to binary encoder for the 8-bit bank select.
// onehot : bank select vector
// idx    : index of the set bit (meaningful only when neither flag is set)
// zero   : no bit set
// multi  : more than one bit set
module minimig_onehot_enc
    import minimig_mem_pkg::*;
(
    input  logic [BANK_W-1:0]     onehot,
    output logic [BANK_IDX_W-1:0] idx,
    output logic                  zero,
    output logic                  multi
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < BANK_W; i++) begin
            if (onehot[i]) begin
                idx = i[BANK_IDX_W-1:0];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        zero  = (onehot == '0);
        multi = |(onehot & (onehot - BANK_W'(1)));
    end

endmodule

// File: rtl/minimig_bank_responder.sv
// Memory-side responder for the one-hot bank select. Validates the select,
// runs one handshaken access on the RAM/ROM port and answers the master.
// clk, reset_n : clock, asynchronous active-low reset
// bus          : request/response interface (slave side)
// mem_*        : physical memory port; mem_addr = {bank index, ofs}
module minimig_bank_responder
    import minimig_mem_pkg::*;
#(
    parameter int unsigned OFS_W   = 18,
    parameter int unsigned TIMEOUT = 255
)(
    input  logic                   clk,
    input  logic                   reset_n,
    minimig_bank_responder_if.slave bus,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [OFS_W+2:0]       mem_addr,
    output logic [15:0]            mem_wdata,
    output logic [1:0]             mem_be,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_rdata
);

    localparam logic [15:0] TMO_LIMIT = TIMEOUT[15:0];

    state_t                  state;
    logic [15:0]             tmo_cnt;
    logic [15:0]             tmo_next;
    logic [BANK_IDX_W-1:0]   enc_idx;
    logic                    enc_zero;
    logic                    enc_multi;

    minimig_onehot_enc u_enc (
        .onehot (bus.bank),
        .idx    (enc_idx),
        .zero   (enc_zero),
        .multi  (enc_multi)
    );

    always_comb begin
        tmo_next = tmo_cnt + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            bus.ack      <= 1'b0;
            bus.berr     <= 1'b0;
            bus.unmapped <= 1'b0;
            bus.rdata    <= UNMAPPED_READ;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        state <= RESP;
                        if (enc_zero) begin
                            bus.ack      <= 1'b1;
                            bus.unmapped <= 1'b1;
                            if (!bus.we) begin
                                bus.rdata <= UNMAPPED_READ;
                            end
                        end else if (enc_multi) begin
                            bus.berr <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= bus.we;
                            mem_addr  <= {enc_idx, bus.ofs};
                            mem_wdata <= bus.wdata;
                            mem_be    <= bus.be;
                            tmo_cnt   <= '0;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    tmo_cnt <= tmo_next;
                    // mem_ack takes priority over a timeout on the same cycle
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        bus.ack <= 1'b1;
                        if (!mem_we) begin
                            bus.rdata <= mem_rdata;
                        end
                        state <= RESP;
                    end else if (tmo_next == TMO_LIMIT) begin
                        mem_req  <= 1'b0;
                        bus.berr <= 1'b1;
                        state    <= RESP;
                    end
                end

                RESP: begin
                    bus.ack      <= 1'b0;
                    bus.berr     <= 1'b0;
                    bus.unmapped <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= RELEASE;
                end

                RELEASE: begin
                    if (!bus.req) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minimig_bank_responder.sv
module tb_minimig_bank_responder;
    import minimig_mem_pkg::*;

    localparam int unsigned OFS_W = 18;
    localparam int unsigned TMO   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    minimig_bank_responder_if #(.OFS_W(OFS_W)) bus ();

    logic              mem_req;
    logic              mem_we;
    logic [OFS_W+2:0]  mem_addr;
    logic [15:0]       mem_wdata;
    logic [1:0]        mem_be;
    logic              mem_ack = 1'b0;
    logic [15:0]       mem_rdata = 16'h0000;

    minimig_bank_responder #(.OFS_W(OFS_W), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Transaction view: an outstanding memory access, a pending response
    // pulse, or a wait for the master to drop req.
    logic        m_req = 1'b0, m_we = 1'b0, m_ack = 1'b0, m_berr = 1'b0;
    logic        m_unm = 1'b0, m_hold = 1'b0;
    logic [20:0] m_addr = '0;
    logic [15:0] m_wdata = '0, m_rdata = 16'hFFFF;
    logic [1:0]  m_be = '0;
    logic [2:0]  m_idx;
    int          m_wait = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_req = 0; m_we = 0; m_ack = 0; m_berr = 0; m_unm = 0; m_hold = 0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = 16'hFFFF; m_wait = 0;
        end else if (m_ack || m_berr) begin
            m_ack = 0; m_berr = 0; m_unm = 0; m_hold = 1;
        end else if (m_req) begin
            m_wait++;
            if (mem_ack) begin
                m_req = 0; m_ack = 1;
                if (!m_we) m_rdata = mem_rdata;
            end else if (m_wait == TMO) begin
                m_req = 0; m_berr = 1;
            end
        end else if (m_hold) begin
            if (!bus.req) m_hold = 0;
        end else if (bus.req) begin
            case ($countones(bus.bank))
                0: begin
                    m_ack = 1; m_unm = 1;
                    if (!bus.we) m_rdata = 16'hFFFF;
                end
                1: begin
                    m_idx = 3'd0;
                    for (int i = 0; i < 8; i++)
                        if (bus.bank == (8'd1 << i)) m_idx = 3'(i);
                    m_req = 1; m_wait = 0; m_we = bus.we;
                    m_addr = {m_idx, bus.ofs}; m_wdata = bus.wdata; m_be = bus.be;
                end
                default: m_berr = 1;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("ack", bus.ack, m_ack);
        chk("berr", bus.berr, m_berr);
        chk("unmapped", bus.unmapped, m_unm);
        chk("rdata", bus.rdata, m_rdata);
        chk("mem_req", mem_req, m_req);
        if (m_req) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_be", mem_be, m_be);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic w, input logic [7:0] b, input logic [17:0] o,
                         input logic [15:0] d, input logic [1:0] e);
        bus.we = w; bus.bank = b; bus.ofs = o; bus.wdata = d; bus.be = e;
        bus.req = 1'b1;
    endtask

    task automatic wait_mem(output int cycles);
        cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cycles++;
            if (mem_req) break;
        end
        if (!mem_req) chk("mem_req_rise", 0, 1);
    endtask

    // Assert mem_ack during the lat-th cycle of the access (counted from the
    // first cycle mem_req is seen high), then return on the following negedge.
    task automatic pulse_ack(input int lat, input logic [15:0] data);
        repeat (lat - 1) @(negedge clk);
        mem_ack = 1'b1; mem_rdata = data;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic wait_resp(output int cycles);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.ack || bus.berr) break;
        end
        if (!(bus.ack || bus.berr)) chk("resp_timeout", 0, 1);
    endtask

    task automatic finish_req();
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n;
    logic [20:0] a;

    initial begin
        bus.req = 0; bus.we = 0; bus.bank = '0; bus.ofs = '0; bus.wdata = '0; bus.be = '0;
        @(negedge clk);
        chk("rst_ack", bus.ack, 0);
        chk("rst_rdata", bus.rdata, 16'hFFFF);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Read, chip block 0, memory answers on third cycle
        drive(0, 8'h01, 18'h00010, 16'h0, 2'b11);
        wait_mem(n);
        chk("rd_req_latency", n, 1);
        chk("rd_mem_addr", mem_addr, 21'h000010);
        chk("rd_mem_we", mem_we, 0);
        pulse_ack(3, 16'hBEEF);
        chk("rd_ack", bus.ack, 1);
        chk("rd_berr", bus.berr, 0);
        chk("rd_rdata", bus.rdata, 16'hBEEF);
        finish_req();

        // Write, slow0, top offset, upper byte only
        drive(1, 8'h10, 18'h3FFFF, 16'h1234, 2'b10);
        wait_mem(n);
        chk("wr_mem_addr", mem_addr, 21'h13FFFF);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_be", mem_be, 2'b10);
        chk("wr_mem_wdata", mem_wdata, 16'h1234);
        pulse_ack(2, 16'h7777);
        chk("wr_ack", bus.ack, 1);
        chk("wr_rdata_kept", bus.rdata, 16'hBEEF);
        finish_req();

        // Unmapped write leaves rdata alone
        drive(1, 8'h00, 18'h00001, 16'h5555, 2'b11);
        wait_resp(n);
        chk("unm_wr_ack", bus.ack, 1);
        chk("unm_wr_rdata", bus.rdata, 16'hBEEF);
        finish_req();

        // Unmapped read
        drive(0, 8'h00, 18'h00002, 16'h0, 2'b11);
        wait_resp(n);
        chk("unm_rd_latency", n, 1);
        chk("unm_rd_ack", bus.ack, 1);
        chk("unm_rd_unmapped", bus.unmapped, 1);
        chk("unm_rd_rdata", bus.rdata, 16'hFFFF);
        @(negedge clk);
        chk("unm_rd_ack_one_cycle", bus.ack, 0);
        finish_req();

        // Multiple bits set: bus error
        drive(0, 8'h81, 18'h00003, 16'h0, 2'b11);
        wait_resp(n);
        chk("multi_berr", bus.berr, 1);
        chk("multi_ack", bus.ack, 0);
        chk("multi_no_mem", mem_req, 0);
        finish_req();

        // mem_ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 16'h0BAD;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_ack_ignored", bus.ack, 0);

        // Kickstart bank, index 7
        drive(0, 8'h80, 18'h12345, 16'h0, 2'b11);
        wait_mem(n);
        chk("kick_mem_addr", mem_addr, 21'h1D2345);
        pulse_ack(1, 16'hA1A1);
        chk("kick_rdata", bus.rdata, 16'hA1A1);
        finish_req();

        // Timeout: no mem_ack
        drive(0, 8'h04, 18'h00020, 16'h0, 2'b11);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req) n++;
            else if (n > 0) break;
        end
        chk("tmo_req_cycles", n, TMO);
        chk("tmo_berr", bus.berr, 1);
        chk("tmo_ack", bus.ack, 0);
        finish_req();

        // mem_ack on the last allowed cycle wins over the timeout
        drive(0, 8'h08, 18'h00021, 16'h0, 2'b11);
        wait_mem(n);
        pulse_ack(TMO, 16'hCAFE);
        chk("tmo_edge_ack", bus.ack, 1);
        chk("tmo_edge_berr", bus.berr, 0);
        chk("tmo_edge_rdata", bus.rdata, 16'hCAFE);
        finish_req();

        // Reset during ISSUE
        drive(0, 8'h01, 18'h00030, 16'h0, 2'b11);
        wait_mem(n);
        #2 reset_n = 1'b0;
        #1 chk("rst_mid_mem_req", mem_req, 0);
        bus.req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack || bus.berr) n++;
        end
        chk("rst_mid_no_resp", n, 0);

        drive(0, 8'h02, 18'h00040, 16'h0, 2'b11);
        wait_mem(n);
        a = mem_addr;
        chk("post_rst_idx", a[20:18], 3'd1);
        pulse_ack(2, 16'h5A5A);
        chk("post_rst_ack", bus.ack, 1);
        chk("post_rst_rdata", bus.rdata, 16'h5A5A);
        finish_req();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
